// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, size encodings and control-bit positions for the memory stage.
package mem_stage_pkg;
    localparam int WORD_SIZE = 32;
    localparam int REG_SIZE = 5;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_BITS = 8;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;
    localparam int MC_READ = 4;
    localparam int MC_WRITE = 3;
    localparam int MC_UNSIGNED = 2;
    localparam int MC_SIZE_HI = 1;
    localparam int MC_SIZE_LO = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_ILL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: word array with per-byte-lane synchronous write and asynchronous read.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data memory access with alignment check, load extension and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int reg_size = REG_SIZE,
    parameter int mem_depth = MEM_DEPTH,
    parameter int addr_bits = ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [word_size-1:0] AluResultIn,
    input  logic [word_size-1:0] StoreData,
    input  logic [reg_size-1:0]  destination_reg_in,
    input  logic [4:0]           mem_control_signals,
    input  logic [1:0]           wb_control_signals_in,
    output logic [word_size-1:0] ReadData,
    output logic [word_size-1:0] AluResult,
    output logic [reg_size-1:0]  destination_reg,
    output logic [1:0]           wb_control_signals,
    output logic                 misaligned
);
    logic mem_read, mem_write, load_unsigned, mis, store_en;
    logic [1:0] size, off;
    logic [3:0] we;
    logic [31:0] wdata, rdata, shifted, ext_b, ext_h, load_val;
    logic [word_size-1:0] read_data_d, read_data_q, alu_q;
    logic [reg_size-1:0] dst_q;
    logic [1:0] wb_d, wb_q;
    logic mis_q;
    assign mem_read = mem_control_signals[MC_READ];
    assign mem_write = mem_control_signals[MC_WRITE];
    assign load_unsigned = mem_control_signals[MC_UNSIGNED];
    assign size = mem_control_signals[MC_SIZE_HI:MC_SIZE_LO];
    assign off = AluResultIn[1:0];
    assign mis = (mem_read | mem_write) & is_misaligned(size, off);
    assign store_en = mem_write & ~mis & ~stall & ~flush & ~reset;
    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        we = !store_en ? 4'b0000 :
             size == SZ_BYTE ? 4'b0001 << off :
             size == SZ_HALF ? 4'b0011 << off : 4'b1111;
        wdata = size == SZ_BYTE ? {4{StoreData[7:0]}} :
                size == SZ_HALF ? {2{StoreData[15:0]}} : StoreData[31:0];
    end
    data_mem #(.DEPTH(mem_depth), .AW(addr_bits)) u_data_mem (
        .clk    (clk),
        .we_i   (we),
        .addr_i (AluResultIn[addr_bits+1:2]),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        ext_b = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
        ext_h = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
        load_val = size == SZ_BYTE ? ext_b : size == SZ_HALF ? ext_h : rdata;
        read_data_d = (mem_read & ~mem_write & ~mis) ? load_val : '0;
        wb_d = {wb_control_signals_in[WB_REGWRITE] & ~mis, wb_control_signals_in[WB_MEMTOREG]};
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            read_data_q <= '0;
            alu_q <= '0;
            dst_q <= '0;
            wb_q <= '0;
            mis_q <= 1'b0;
        end else if (!stall) begin
            read_data_q <= read_data_d;
            alu_q <= AluResultIn;
            dst_q <= destination_reg_in;
            wb_q <= wb_d;
            mis_q <= mis;
        end
    end
    assign ReadData = read_data_q;
    assign AluResult = alu_q;
    assign destination_reg = dst_q;
    assign wb_control_signals = wb_q;
    assign misaligned = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random steps checked against a byte-addressed reference memory.
module tb_mem_stage;
    localparam logic [4:0] LW = 5'b10010, LH = 5'b10001, LHU = 5'b10101, LB = 5'b10000, LBU = 5'b10100;
    localparam logic [4:0] SW = 5'b01010, SH = 5'b01001, SB = 5'b01000, NOP = 5'b00000;
    logic clk = 1'b0;
    logic reset, stall, flush;
    logic [31:0] alu_in, sd;
    logic [4:0] dst_in, mc;
    logic [1:0] wb_in;
    logic [31:0] read_data, alu_out;
    logic [4:0] dst_out;
    logic [1:0] wb_out;
    logic mis_out;
    logic [7:0] mem_m [1024];
    logic [31:0] e_rd = '0, e_alu = '0;
    logic [4:0] e_dst = '0;
    logic [1:0] e_wb = '0;
    logic e_mis = 1'b0;
    int passed = 0, total = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .AluResultIn(alu_in), .StoreData(sd), .destination_reg_in(dst_in),
        .mem_control_signals(mc), .wb_control_signals_in(wb_in),
        .ReadData(read_data), .AluResult(alu_out), .destination_reg(dst_out),
        .wb_control_signals(wb_out), .misaligned(mis_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // The model treats memory as 1024 bytes and loads as little-endian numbers.
    task automatic step(input logic rst, input logic st, input logic fl, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] dst, input logic [4:0] c,
                        input logic [1:0] wb, input string tag);
        bit r, w, u, m;
        int n, ad;
        longint v;
        @(negedge clk);
        reset = rst; stall = st; flush = fl; alu_in = a; sd = d; dst_in = dst; mc = c; wb_in = wb;
        r = c[4]; w = c[3]; u = c[2];
        n = (c[1:0] == 2'b11) ? 0 : (1 << c[1:0]);
        ad = int'(a[9:0]);
        m = (r || w) && (n == 0 || ad % n != 0);
        v = 0;
        if (r && !w && !m) begin
            for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mem_m[(ad + i) % 1024]);
            if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        end
        if (rst || fl) begin
            e_rd = '0; e_alu = '0; e_dst = '0; e_wb = '0; e_mis = 1'b0;
        end else if (!st) begin
            e_rd = v[31:0]; e_alu = a; e_dst = dst; e_wb = {wb[1] && !m, wb[0]}; e_mis = m;
        end
        if (!rst && !fl && !st && w && !m)
            for (int i = 0; i < n; i++) mem_m[(ad + i) % 1024] = d[8*i +: 8];
        @(posedge clk);
        #1;
        chk({tag, ".rd"}, read_data, e_rd);
        chk({tag, ".alu"}, alu_out, e_alu);
        chk({tag, ".dst"}, {27'd0, dst_out}, {27'd0, e_dst});
        chk({tag, ".wb"}, {30'd0, wb_out}, {30'd0, e_wb});
        chk({tag, ".mis"}, {31'd0, mis_out}, {31'd0, e_mis});
    endtask

    initial begin
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, NOP, 2'b00, "reset");
        for (int i = 0; i < 256; i++)
            step(0, 0, 0, i * 4, $urandom, 5'(i), SW, 2'b00, "init");
        step(0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd1, SW, 2'b00, "sw10");
        step(0, 0, 0, 32'h10, 32'h0, 5'd2, LW, 2'b11, "lw10");
        chk("lw10_const", read_data, 32'hDEADBEEF);
        step(0, 0, 0, 32'h13, 32'h0, 5'd3, LB, 2'b11, "lb13");
        chk("lb13_const", read_data, 32'hFFFFFFDE);
        step(0, 0, 0, 32'h13, 32'h0, 5'd3, LBU, 2'b11, "lbu13");
        chk("lbu13_const", read_data, 32'h000000DE);
        step(0, 0, 0, 32'h12, 32'h0, 5'd4, LH, 2'b11, "lh12");
        chk("lh12_const", read_data, 32'hFFFFDEAD);
        step(0, 0, 0, 32'h10, 32'h0, 5'd4, LHU, 2'b11, "lhu10");
        chk("lhu10_const", read_data, 32'h0000BEEF);
        step(0, 0, 0, 32'h11, 32'h55, 5'd0, SB, 2'b00, "sb11");
        step(0, 0, 0, 32'h10, 32'h0, 5'd5, LW, 2'b11, "lw10b");
        chk("sb_merge_const", read_data, 32'hDEAD55EF);
        step(0, 0, 0, 32'h12, 32'h0, 5'd6, LW, 2'b11, "lw12_mis");
        chk("mis_flag_const", {31'd0, mis_out}, 32'd1);
        chk("mis_regwrite_const", {30'd0, wb_out}, 32'd1);
        step(0, 0, 0, 32'h21, 32'hA5A5, 5'd0, SH, 2'b00, "sh21_mis");
        step(0, 0, 0, 32'h20, 32'h0, 5'd7, LW, 2'b11, "lw20");
        step(0, 1, 0, 32'h30, 32'hCAFEF00D, 5'd0, SW, 2'b00, "sw30_stall1");
        step(0, 1, 0, 32'h30, 32'hCAFEF00D, 5'd0, SW, 2'b00, "sw30_stall2");
        step(0, 0, 0, 32'h30, 32'h0, 5'd8, LW, 2'b11, "lw30_old");
        step(0, 0, 0, 32'h30, 32'hCAFEF00D, 5'd0, SW, 2'b00, "sw30");
        step(0, 0, 0, 32'h30, 32'h0, 5'd9, LW, 2'b11, "lw30_new");
        chk("lw30_const", read_data, 32'hCAFEF00D);
        step(0, 1, 1, 32'h34, 32'h0, 5'd10, LW, 2'b11, "flush_stall");
        step(1, 0, 0, 32'h40, 32'h12345678, 5'd11, SW, 2'b10, "reset_sw40");
        step(0, 0, 0, 32'h40, 32'h0, 5'd12, LW, 2'b11, "lw40");
        step(0, 0, 0, 32'h400, 32'h0, 5'd13, LW, 2'b11, "lw400_wrap");
        step(0, 0, 0, 32'h0, 32'h0, 5'd13, LW, 2'b11, "lw0");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom & 32'hFFFF_F03F, $urandom, 5'($urandom), 5'($urandom), 2'($urandom), "rand");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
